// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   sr_mode_e    : 3-bit operation code applied on each step
//   is_shift_op  : true for the four modes that advance the frame counter
package shift_pkg;

    typedef enum logic [2:0] {
        SR_HOLD = 3'b000,
        SR_SHL  = 3'b001,
        SR_SHR  = 3'b010,
        SR_ROL  = 3'b011,
        SR_ROR  = 3'b100,
        SR_LOAD = 3'b101,
        SR_CLR  = 3'b110,
        SR_RSVD = 3'b111
    } sr_mode_e;

    function automatic logic is_shift_op(input sr_mode_e m);
        return (m == SR_SHL) || (m == SR_SHR) || (m == SR_ROL) || (m == SR_ROR);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: two-FF synchroniser, stability debouncer and rising-edge pulse.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset; discards any partially debounced press
//   i_btn    : raw asynchronous button
//   o_rise   : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            r_level;
    logic            r_level_prev;
    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync       <= 2'b00;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync       <= {r_sync[0], i_btn};
            r_level_prev <= r_level;
            // Count consecutive cycles of disagreement; any agreement restarts the count.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntMax) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_rise = r_level & ~r_level_prev;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register stepped either by a debounced button or a free-running prescaler.
//   i_clk          : system clock
//   i_rst          : synchronous active-high reset
//   i_btn          : raw step button
//   i_auto_en      : 1 = step on prescaler tick (button ignored), 0 = step on button press
//   i_mode         : operation applied on each step (see shift_pkg::sr_mode_e)
//   i_serial_in    : bit entering on shift operations
//   i_par_in       : parallel load value
//   o_q            : register contents
//   o_serial_out   : last bit shifted or rotated out
//   o_frame_done   : one-cycle pulse when WIDTH shift/rotate steps have completed
module shift_register_universal
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV        = 50_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn,
    input  logic             i_auto_en,
    input  logic [2:0]       i_mode,
    input  logic             i_serial_in,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_q,
    output logic             o_serial_out,
    output logic             o_frame_done
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned FcW   = $clog2(WIDTH);
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam logic [FcW-1:0]   FcMax   = FcW'(WIDTH - 1);

    logic             w_btn_rise;
    logic             w_tick;
    logic             w_step;
    sr_mode_e         w_mode;

    logic [TickW-1:0] r_tick_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_serial_out;
    logic             r_frame_done;
    logic [FcW-1:0]   r_fc;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn),
        .o_rise (w_btn_rise)
    );

    // Prescaler free-runs regardless of i_auto_en so toggling the source keeps its phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TickMax) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TickW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TickMax);
    assign w_step = i_auto_en ? w_tick : w_btn_rise;
    assign w_mode = sr_mode_e'(i_mode);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q          <= '0;
            r_serial_out <= 1'b0;
            r_frame_done <= 1'b0;
            r_fc         <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_step) begin
                case (w_mode)
                    SR_SHL: begin
                        r_q          <= {r_q[WIDTH-2:0], i_serial_in};
                        r_serial_out <= r_q[WIDTH-1];
                    end
                    SR_SHR: begin
                        r_q          <= {i_serial_in, r_q[WIDTH-1:1]};
                        r_serial_out <= r_q[0];
                    end
                    SR_ROL: begin
                        r_q          <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        r_serial_out <= r_q[WIDTH-1];
                    end
                    SR_ROR: begin
                        r_q          <= {r_q[0], r_q[WIDTH-1:1]};
                        r_serial_out <= r_q[0];
                    end
                    SR_LOAD: begin
                        r_q  <= i_par_in;
                        r_fc <= '0;
                    end
                    SR_CLR: begin
                        r_q  <= '0;
                        r_fc <= '0;
                    end
                    default: begin
                        // SR_HOLD and SR_RSVD leave everything unchanged.
                    end
                endcase

                if (is_shift_op(w_mode)) begin
                    if (r_fc == FcMax) begin
                        r_fc         <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_fc <= r_fc + FcW'(1);
                    end
                end
            end
        end
    end

    assign o_q          = r_q;
    assign o_serial_out = r_serial_out;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register for the board's switch/button/LED labs. It generalises the 8-bit serial-in/parallel-out register to any width and eight modes: hold, shift, rotate, parallel load and clear. It adds an on-chip debounced, edge-detected button step and a free-running auto-step prescaler. A frame counter flags every WIDTH shift operations.

## Interface
- WIDTH, 8, register width; must be ≥2
- DEBOUNCE_CYCLES, 1_000_000, cycles btn must be stable before a level change is accepted; must be ≥1
- TICK_DIV, 50_000_000, auto-step period in clk cycles; must be ≥2
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- btn  in  1  raw asynchronous step button
- auto_en  in  1  1 = step on prescaler tick and ignore btn; 0 = step on debounced btn press
- mode  in  3  operation applied on each step, see Operation
- serial_in  in  1  bit entering on shift operations
- par_in  in  WIDTH  parallel load value
- q  out  WIDTH  register contents (drives led)
- serial_out  out  1  last bit shifted or rotated out (registered)
- frame_done  out  1  one-cycle pulse when WIDTH shift/rotate steps have completed

## Operation
- Step source:
  - btn path: two-FF synchroniser, then debouncer, then rising-edge detect, which gives one step per accepted press.
  - Prescaler: runs continuously 0..TICK_DIV-1. tick is asserted when the count equals TICK_DIV-1.
  - step = auto_en ? tick : btn_edge. The two sources are never combined.
- Debouncer:
  - The counter increments each cycle that the synchronised level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level flips on the next edge.
  - Only rising flips produce a step.
- mode is sampled only in the step cycle. With no step, q, serial_out and the frame counter hold.
- Modes:
  - 000 hold
  - 001 shift left: q ← {q[W-2:0], serial_in}; serial_out ← q[W-1]
  - 010 shift right: q ← {serial_in, q[W-1:1]}; serial_out ← q[0]
  - 011 rotate left: serial_out ← q[W-1]
  - 100 rotate right: serial_out ← q[0]
  - 101 load: q ← par_in
  - 110 clear: q ← 0
  - 111 hold (reserved)
- Frame counter: width $clog2(WIDTH).
  - Increments modulo WIDTH on each shift or rotate step.
  - When it wraps from WIDTH-1 to 0, frame_done pulses for one cycle, coincident with the q update becoming visible.
  - Load and clear reset the counter to 0 and do not pulse frame_done.
  - Hold modes leave it unchanged.

## Timing
- Reset values: q=0, serial_out=0, frame_done=0. Synchroniser, debounce level, debounce counter, prescaler and frame counter are all 0.
- Reset mid-operation:
  - All state returns to the reset values on the edge rst is sampled high. A partially debounced press is discarded.
  - If btn is held high through reset, it is treated as a new press after deassertion.
- Button latency: btn goes high before edge 1 and stays clean.
  - Synchronised level is high after edge 2.
  - Debounced level is high after edge 2+DEBOUNCE_CYCLES.
  - q updates at edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no step. Release is debounced identically.
- Auto mode:
  - Exactly one step per TICK_DIV cycles.
  - The first tick after reset updates q at edge TICK_DIV.
  - Toggling auto_en does not reset the prescaler.
- Simultaneous events:
  - rst has priority over everything.
  - btn activity while auto_en=1 is still debounced. A press completing while auto_en=1 is dropped.
- serial_out and frame_done are registered and update on the same edge as q.

## Structure
- Package shift_pkg holds the mode encodings (enum/localparams SR_HOLD … SR_RSVD).
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser, debounce counter and rising-edge pulse output.
- Top level contains the prescaler, step mux, register datapath and frame counter.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4, TICK_DIV=4.
1. Shift-left fill: reset, mode=001, serial_in=1, three clean presses. Required: q=8'h07, serial_out=0, no frame_done.
2. Load and full rotate:
   - Load par_in=8'hA5 with mode=101 and one press. Required: q=8'hA5.
   - Then mode=011 and 8 presses. Required: q=8'hA5, with frame_done pulsing exactly once, on the 8th update.
3. Bounce rejection: from q=8'h00, btn pulses high for 2 cycles, low for 2, repeated 10 times, then low. Required: no step, q=8'h00.
4. Auto shift-right:
   - Required: with q=0, auto_en=1, mode=010, serial_in=1, q=8'h80 at edge 4 and 8'hFF at edge 32.
   - Required: frame_done at edge 32 and again at edge 64.
   - Required: btn presses during this have no effect.
5. Reset and latency:
   - With q=8'h3C mid-frame, assert rst for 1 cycle with btn held high and mode=110. Required: q=8'h00 on the reset edge.
   - Required: exactly one clear step occurs, at edge 7 after rst deasserts, and no further steps while btn stays high.
6. Single press latency: mode=001, serial_in=1, btn goes high before edge 1. Required: q changes at edge 7 (3+DEBOUNCE_CYCLES) and not before.
